fnd_scan_ctrl: RTL

Parametrised multiplexed 7-segment (FND) scan controller, the next generation of the free-running 2-bit digit counter. It time-multiplexes DIGITS hex nibbles onto a shared segment bus. The block adds a scan-rate prescaler, an anti-ghosting blank interval, frame-coherent value capture, leading-zero blanking and a frame tick. It sits between the value-producing logic and the board's FND pins.

---
 rtl/fnd_pkg.sv | 64 ++++++
 rtl/fnd_hex_decoder.sv | 14 +
 rtl/fnd_scan_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND (7-segment) display blocks: glyph table,
// segment bit ordering and the all-off drive constants.
package fnd_pkg;

    // Segment vectors. Bit order is {dp,g,f,e,d,c,b,a}, all active-low.
    typedef logic [6:0] seg7_t;
    typedef logic [7:0] seg8_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark (active-low, so every bit high).
    localparam seg7_t SEG7_OFF = 7'h7F;
    localparam seg8_t SEG_OFF  = 8'hFF;

    // Active-low hex glyphs {g,f,e,d,c,b,a} for 0..F.
    localparam seg7_t GLYPH_0 = 7'h40;
    localparam seg7_t GLYPH_1 = 7'h79;
    localparam seg7_t GLYPH_2 = 7'h24;
    localparam seg7_t GLYPH_3 = 7'h30;
    localparam seg7_t GLYPH_4 = 7'h19;
    localparam seg7_t GLYPH_5 = 7'h12;
    localparam seg7_t GLYPH_6 = 7'h02;
    localparam seg7_t GLYPH_7 = 7'h78;
    localparam seg7_t GLYPH_8 = 7'h00;
    localparam seg7_t GLYPH_9 = 7'h10;
    localparam seg7_t GLYPH_A = 7'h08;
    localparam seg7_t GLYPH_B = 7'h03;
    localparam seg7_t GLYPH_C = 7'h46;
    localparam seg7_t GLYPH_D = 7'h21;
    localparam seg7_t GLYPH_E = 7'h06;
    localparam seg7_t GLYPH_F = 7'h0E;

    // Nibble to active-low glyph lookup.
    function automatic seg7_t hex_glyph(input logic [3:0] nib);
        seg7_t g;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fnd_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder.
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg7
);

    // Pure table lookup; no state.
    always_comb begin
        o_seg7 = hex_glyph(i_nibble);
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed FND scan controller: prescaled digit scan with blank interval,
// frame-coherent value capture, leading-zero blanking and a frame tick.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter  int DIGITS       = 4,
    parameter  int SCAN_DIV     = 100000,
    parameter  int BLANK_CYCLES = 1000,
    localparam int IW           = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_lzb,
    output logic [DIGITS-1:0]     o_digit,
    output logic [7:0]            o_seg,
    output logic [IW-1:0]         o_index,
    output logic                  o_frame_tick
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]     dpl_q, dpl_d;

    logic [DIGITS-1:0]     digit_q, digit_d;
    logic [7:0]            seg_q, seg_d;
    logic [IW-1:0]         index_q, index_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_glyph;
    logic [DIGITS-1:0]     lead_zero;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);
    assign cur_nib    = val_q[4*idx_q +: 4];

    fnd_hex_decoder u_dec (
        .i_nibble (cur_nib),
        .o_seg7   (cur_glyph)
    );

    // Leading-zero mask: digit k>0 is flagged when it and every higher nibble are zero.
    always_comb begin
        logic hi_zero;
        hi_zero   = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero      = hi_zero && (val_q[4*k +: 4] == 4'h0);
            lead_zero[k] = hi_zero && (k != 0);
        end
    end

    // Scan counters and capture registers; capture only at frame wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        val_d = val_q;
        dpl_d = dpl_q;
        if (!i_enable) begin
            cnt_d = '0;
            idx_d = '0;
            val_d = i_value;
            dpl_d = i_dp;
        end else if (slot_end) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                val_d = i_value;
                dpl_d = i_dp;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output drive from the current state; disable forces everything dark at once.
    always_comb begin
        digit_d = '1;
        seg_d   = SEG_OFF;
        index_d = '0;
        tick_d  = 1'b0;
        if (i_enable) begin
            index_d = idx_q;
            tick_d  = frame_wrap;
            if (cnt_q >= CNT_BLANK) begin
                digit_d = ~(DIGITS'(1) << idx_q);
                seg_d   = {~dpl_q[idx_q], (i_lzb && lead_zero[idx_q]) ? SEG7_OFF : cur_glyph};
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dpl_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dpl_q <= dpl_d;
        end
    end

    // Output registers; asynchronous reset darkens the display immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit_q <= '1;
            seg_q   <= SEG_OFF;
            index_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            seg_q   <= seg_d;
            index_q <= index_d;
            tick_q  <= tick_d;
        end
    end

    assign o_digit      = digit_q;
    assign o_seg        = seg_q;
    assign o_index      = index_q;
    assign o_frame_tick = tick_q;

endmodule
